// File: rtl/qdrc_pkg.sv
// Shared constants and helpers for the QDR controller blocks.
package qdrc_pkg;

    localparam int QDR_DATA_WIDTH  = 36;
    localparam int QDR_TAG_WIDTH   = 4;
    localparam int QDR_LAT_MIN     = 2;
    localparam int QDR_LAT_DEFAULT = 9;

    // Ceiling log2, usable in parameter expressions.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result++;
        end
        return result;
    endfunction

endpackage

// File: rtl/qdrc_rd_pipe_if.sv
// User read port and PHY read-side signals of the QDR read-return path.
interface qdrc_rd_pipe_if
    import qdrc_pkg::*;
#(
    parameter int DATA_WIDTH = QDR_DATA_WIDTH,
    parameter int TAG_WIDTH  = QDR_TAG_WIDTH
) ();

    logic                    phy_rdy;
    logic                    phy_strb;
    logic [2*DATA_WIDTH-1:0] phy_data;
    logic                    usr_strb;
    logic [TAG_WIDTH-1:0]    usr_tag;
    logic                    usr_ack;
    logic [2*DATA_WIDTH-1:0] usr_data;
    logic [TAG_WIDTH-1:0]    usr_dtag;
    logic                    usr_dvld;
    logic                    usr_rdy;

    // Environment side: user requester plus PHY.
    modport master (
        output phy_rdy, phy_data, usr_strb, usr_tag, usr_rdy,
        input  phy_strb, usr_ack, usr_data, usr_dtag, usr_dvld
    );

    // Read-return pipe side.
    modport slave (
        input  phy_rdy, phy_data, usr_strb, usr_tag, usr_rdy,
        output phy_strb, usr_ack, usr_data, usr_dtag, usr_dvld
    );

endinterface

// File: rtl/qdrc_rd_fifo.sv
// Synchronous first-word-fall-through FIFO; head data reads as zero while empty.
module qdrc_rd_fifo
    import qdrc_pkg::*;
#(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 16,
    localparam int AW    = clog2(DEPTH),
    localparam int CW    = clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign full      = (count == CW'(DEPTH));
    assign empty     = (count == '0);
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign push_ok   = push & (~full | pop);
    assign pop_ok    = pop & ~empty;
    assign head_data = empty ? '0 : mem[rd_ptr];

    // NOTE: storage has no reset; the empty flag masks stale contents, so clearing it buys nothing.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // NOTE: clocked blocks use <= only, so every register sees pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/qdrc_rd_pipe.sv
// QDR read-return path: credit-controlled strobe issue, tag tracking through a
// programmable-latency pipeline, and an output FIFO with user backpressure.
module qdrc_rd_pipe
    import qdrc_pkg::*;
#(
    parameter  int DATA_WIDTH  = QDR_DATA_WIDTH,
    parameter  int TAG_WIDTH   = QDR_TAG_WIDTH,
    parameter  int MAX_LATENCY = 16,
    parameter  int FIFO_DEPTH  = 16,
    localparam int LAT_WIDTH   = clog2(MAX_LATENCY + 1),
    localparam int CNT_WIDTH   = clog2(FIFO_DEPTH + 1)
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [LAT_WIDTH-1:0] cfg_latency,
    output logic [LAT_WIDTH:0]   inflight,
    output logic                 err_ovf,
    qdrc_rd_pipe_if.slave        bus
);

    localparam int SUM_WIDTH = ((CNT_WIDTH > LAT_WIDTH + 1) ? CNT_WIDTH : LAT_WIDTH + 1) + 1;
    localparam int ENTRY_W   = TAG_WIDTH + 2 * DATA_WIDTH;

    logic [LAT_WIDTH-1:0] l_act;
    logic                 pipe_vld [1:MAX_LATENCY];
    logic [TAG_WIDTH-1:0] pipe_tag [1:MAX_LATENCY];
    logic                 tap_vld;
    logic [TAG_WIDTH-1:0] tap_tag;
    logic [SUM_WIDTH-1:0] credit_sum;
    logic                 credit_ok;
    logic [CNT_WIDTH-1:0] fifo_count;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 fifo_pop;
    logic [ENTRY_W-1:0]   fifo_head;

    function automatic logic [LAT_WIDTH-1:0] clamp_latency(input logic [LAT_WIDTH-1:0] lat);
        if (lat < LAT_WIDTH'(QDR_LAT_MIN)) return LAT_WIDTH'(QDR_LAT_MIN);
        if (lat > LAT_WIDTH'(MAX_LATENCY)) return LAT_WIDTH'(MAX_LATENCY);
        return lat;
    endfunction

    // Every issued read owns a FIFO slot until it is consumed, so the FIFO cannot overflow.
    assign credit_sum   = SUM_WIDTH'(fifo_count) + SUM_WIDTH'(inflight);
    assign credit_ok    = (credit_sum < SUM_WIDTH'(FIFO_DEPTH));
    assign bus.usr_ack  = bus.usr_strb & bus.phy_rdy & credit_ok & reset_n;
    assign bus.phy_strb = bus.usr_ack;

    assign tap_vld = pipe_vld[l_act];
    assign tap_tag = pipe_tag[l_act];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 1; k <= MAX_LATENCY; k++) begin
                pipe_vld[k] <= 1'b0;
                pipe_tag[k] <= '0;
            end
        end else begin
            pipe_vld[1] <= bus.usr_ack;
            pipe_tag[1] <= bus.usr_tag;
            // Entries die at the tap so a later, longer latency never recaptures them.
            for (int k = 2; k <= MAX_LATENCY; k++) begin
                pipe_vld[k] <= pipe_vld[k-1] && (LAT_WIDTH'(k - 1) != l_act);
                pipe_tag[k] <= pipe_tag[k-1];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            l_act    <= LAT_WIDTH'(QDR_LAT_MIN);
            inflight <= '0;
            err_ovf  <= 1'b0;
        end else begin
            // Latency only moves with the pipeline empty, so outstanding reads keep theirs.
            if (inflight == '0 && !bus.usr_ack) begin
                l_act <= clamp_latency(cfg_latency);
            end
            case ({bus.usr_ack, tap_vld})
                2'b10:   inflight <= inflight + (LAT_WIDTH + 1)'(1);
                2'b01:   inflight <= inflight - (LAT_WIDTH + 1)'(1);
                default: inflight <= inflight;
            endcase
            if (tap_vld && fifo_full && !fifo_pop) begin
                err_ovf <= 1'b1;
            end
        end
    end

    assign fifo_pop = ~fifo_empty & bus.usr_rdy;

    qdrc_rd_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (tap_vld),
        .push_data ({tap_tag, bus.phy_data}),
        .pop       (fifo_pop),
        .head_data (fifo_head),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign bus.usr_dvld = ~fifo_empty;
    assign bus.usr_dtag = fifo_head[ENTRY_W-1 -: TAG_WIDTH];
    assign bus.usr_data = fifo_head[2*DATA_WIDTH-1:0];

endmodule

// File: tb/tb_qdrc_rd_pipe.sv
// Randomised and directed bench for qdrc_rd_pipe against a queue-based transaction model.
module tb_qdrc_rd_pipe;
    import qdrc_pkg::*;

    localparam int DW    = QDR_DATA_WIDTH;
    localparam int TW    = QDR_TAG_WIDTH;
    localparam int MAXL  = 16;
    localparam int DEPTH = 16;

    typedef struct {
        int          due;
        logic [3:0]  tag;
        logic [71:0] data;
    } rd_t;

    typedef struct {
        logic [3:0]  tag;
        logic [71:0] data;
    } word_t;

    logic        clk;
    logic        reset_n;
    logic [4:0]  cfg_latency;
    logic [5:0]  inflight;
    logic        err_ovf;

    qdrc_rd_pipe_if #(.DATA_WIDTH(DW), .TAG_WIDTH(TW)) bus ();

    qdrc_rd_pipe #(
        .DATA_WIDTH  (DW),
        .TAG_WIDTH   (TW),
        .MAX_LATENCY (MAXL),
        .FIFO_DEPTH  (DEPTH)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .cfg_latency (cfg_latency),
        .inflight    (inflight),
        .err_ovf     (err_ovf),
        .bus         (bus)
    );

    // Model state: reads in flight with their due edge, and the output FIFO contents.
    rd_t         fl_q[$];
    word_t       fifo_q[$];
    int          edge_n;
    int          l_act_m;
    bit          err_m;
    bit          force_ack;
    bit          use_next;
    logic [71:0] next_word;
    int          ack_seen;
    int          checks;
    int          failures;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [71:0] got, input logic [71:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [71:0] rand72();
        return {8'($urandom), $urandom, $urandom};
    endfunction

    function automatic int clampl(input int c);
        return (c < 2) ? 2 : ((c > MAXL) ? MAXL : c);
    endfunction

    task automatic model_reset();
        fl_q.delete();
        fifo_q.delete();
        l_act_m = 2;
        err_m   = 1'b0;
    endtask

    // One clock cycle: drive inputs after the falling edge, check, clock, advance the model.
    task automatic cycle(input bit strb, input logic [3:0] tag, input bit rdy, input bit prdy);
        logic        exp_ack;
        logic [71:0] exp_data;
        logic [3:0]  exp_tag;
        bit          was_idle;
        bit          pop;
        rd_t         r;
        bus.usr_strb = strb;
        bus.usr_tag  = tag;
        bus.usr_rdy  = rdy;
        bus.phy_rdy  = prdy;
        exp_ack = force_ack || (strb && prdy && (fifo_q.size() + fl_q.size() < DEPTH));
        if (fl_q.size() > 0 && fl_q[0].due == edge_n + 1) bus.phy_data = fl_q[0].data;
        else bus.phy_data = rand72();
        exp_data = (fifo_q.size() > 0) ? fifo_q[0].data : '0;
        exp_tag  = (fifo_q.size() > 0) ? fifo_q[0].tag : '0;
        #1;
        check("usr_ack",  72'(bus.usr_ack),  72'(exp_ack));
        check("phy_strb", 72'(bus.phy_strb), 72'(exp_ack));
        check("usr_dvld", 72'(bus.usr_dvld), 72'(fifo_q.size() > 0));
        check("usr_data", bus.usr_data, exp_data);
        check("usr_dtag", 72'(bus.usr_dtag), 72'(exp_tag));
        check("inflight", 72'(inflight), 72'(fl_q.size()));
        check("err_ovf",  72'(err_ovf),  72'(err_m));
        if (bus.usr_ack) ack_seen++;
        @(posedge clk);
        edge_n++;
        was_idle = (fl_q.size() == 0);
        pop      = (fifo_q.size() > 0) && rdy;
        if (pop) void'(fifo_q.pop_front());
        if (fl_q.size() > 0 && fl_q[0].due == edge_n) begin
            r = fl_q.pop_front();
            if (fifo_q.size() < DEPTH) fifo_q.push_back('{r.tag, r.data});
            else err_m = 1'b1;
        end
        if (exp_ack) fl_q.push_back('{edge_n + l_act_m, tag, use_next ? next_word : rand72()});
        if (was_idle && !exp_ack) l_act_m = clampl(int'(cfg_latency));
        @(negedge clk);
    endtask

    // Cycles from the strobe edge until the word shows at the FIFO head.
    task automatic measure(input string name, input int exp_l);
        int k;
        k = 0;
        while (!bus.usr_dvld && k < 40) begin
            cycle(1'b0, 4'h0, 1'b0, 1'b1);
            k++;
        end
        check(name, 72'(k), 72'(exp_l));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int          sweep [5];
        logic [3:0]  got_tags[$];
        checks   = 0;
        failures = 0;
        edge_n   = 0;
        force_ack = 1'b0;
        use_next  = 1'b0;
        next_word = '0;
        ack_seen  = 0;
        model_reset();
        reset_n      = 1'b0;
        cfg_latency  = 5'(QDR_LAT_DEFAULT);
        bus.usr_strb = 1'b1;
        bus.usr_tag  = 4'h0;
        bus.usr_rdy  = 1'b0;
        bus.phy_rdy  = 1'b1;
        bus.phy_data = '0;

        // Reset state, with a request pending that must not be accepted.
        repeat (2) begin
            @(negedge clk);
            #1;
            check("rst_ack",      72'(bus.usr_ack),  72'(0));
            check("rst_phy_strb", 72'(bus.phy_strb), 72'(0));
            check("rst_dvld",     72'(bus.usr_dvld), 72'(0));
            check("rst_data",     bus.usr_data,      72'(0));
            check("rst_dtag",     72'(bus.usr_dtag), 72'(0));
            check("rst_inflight", 72'(inflight),     72'(0));
            check("rst_err",      72'(err_ovf),      72'(0));
        end
        @(negedge clk);
        reset_n = 1'b1;

        // Single read at latency 9 returning 0xA5 with tag 3.
        repeat (9) cycle(1'b0, 4'h0, 1'b0, 1'b1);
        use_next  = 1'b1;
        next_word = 72'hA5;
        cycle(1'b1, 4'h3, 1'b0, 1'b1);
        use_next  = 1'b0;
        measure("lat_first", 9);
        check("first_dtag", 72'(bus.usr_dtag), 72'(4'h3));
        check("first_data", bus.usr_data, 72'hA5);
        repeat (3) cycle(1'b0, 4'h0, 1'b1, 1'b1);

        // Latency sweep including out-of-range settings.
        sweep = '{2, 5, 16, 0, 31};
        foreach (sweep[i]) begin
            cfg_latency = 5'(sweep[i]);
            repeat (2) cycle(1'b0, 4'h0, 1'b1, 1'b1);
            cycle(1'b1, 4'($urandom), 1'b0, 1'b1);
            measure($sformatf("lat_sweep_%0d", sweep[i]), clampl(sweep[i]));
            repeat (2) cycle(1'b0, 4'h0, 1'b1, 1'b1);
        end

        // Backpressure: credits stop issue at FIFO_DEPTH; one pop frees exactly one slot.
        cfg_latency = 5'd9;
        repeat (2) cycle(1'b0, 4'h0, 1'b1, 1'b1);
        ack_seen = 0;
        repeat (40) cycle(1'b1, 4'($urandom), 1'b0, 1'b1);
        check("bp_acks", 72'(ack_seen), 72'(DEPTH));
        ack_seen = 0;
        cycle(1'b1, 4'h1, 1'b1, 1'b1);
        check("bp_pop_cycle_acks", 72'(ack_seen), 72'(0));
        cycle(1'b1, 4'h2, 1'b0, 1'b1);
        check("bp_next_cycle_acks", 72'(ack_seen), 72'(1));
        repeat (3) cycle(1'b1, 4'h3, 1'b0, 1'b1);
        check("bp_extra_acks", 72'(ack_seen), 72'(1));
        check("bp_err", 72'(err_ovf), 72'(0));
        repeat (40) cycle(1'b0, 4'h0, 1'b1, 1'b1);

        // Latency change 9 -> 4 while three reads are outstanding.
        repeat (3) cycle(1'b1, 4'($urandom), 1'b1, 1'b1);
        cfg_latency = 5'd4;
        repeat (12) cycle(1'b0, 4'h0, 1'b1, 1'b1);
        cycle(1'b1, 4'h7, 1'b0, 1'b1);
        measure("lat_after_change", 4);
        repeat (2) cycle(1'b0, 4'h0, 1'b1, 1'b1);

        // phy_rdy drops with five reads in flight.
        cfg_latency = 5'd9;
        repeat (2) cycle(1'b0, 4'h0, 1'b1, 1'b1);
        for (int t = 1; t <= 5; t++) cycle(1'b1, 4'(t), 1'b0, 1'b1);
        ack_seen = 0;
        for (int n = 0; n < 25; n++) begin
            if (bus.usr_dvld) got_tags.push_back(bus.usr_dtag);
            cycle(1'b1, 4'hF, 1'b1, 1'b0);
        end
        check("rdy_low_acks", 72'(ack_seen), 72'(0));
        check("rdy_low_words", 72'(got_tags.size()), 72'(5));
        foreach (got_tags[i]) check($sformatf("rdy_low_tag_%0d", i), 72'(got_tags[i]), 72'(i + 1));

        // Random traffic with occasional latency reprogramming.
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 49) == 0) cfg_latency = 5'($urandom_range(0, 31));
            cycle($urandom_range(0, 3) != 0, 4'($urandom), $urandom_range(0, 2) != 0,
                  $urandom_range(0, 15) != 0);
        end
        repeat (40) cycle(1'b0, 4'h0, 1'b1, 1'b1);

        // Fault: issue beyond credit so captures meet a full FIFO.
        cfg_latency = 5'd2;
        repeat (3) cycle(1'b0, 4'h0, 1'b1, 1'b1);
        force bus.usr_ack = 1'b1;
        force_ack = 1'b1;
        repeat (24) cycle(1'b0, 4'($urandom), 1'b0, 1'b1);
        release bus.usr_ack;
        force_ack = 1'b0;
        check("ovf_set", 72'(err_ovf), 72'(1));
        repeat (3) cycle(1'b1, 4'($urandom), 1'b1, 1'b1);
        check("ovf_held", 72'(err_ovf), 72'(1));

        // Asynchronous reset in the middle of a burst.
        bus.usr_strb = 1'b1;
        bus.usr_rdy  = 1'b1;
        #3;
        reset_n = 1'b0;
        #1;
        check("arst_dvld",     72'(bus.usr_dvld), 72'(0));
        check("arst_err",      72'(err_ovf),      72'(0));
        check("arst_inflight", 72'(inflight),     72'(0));
        check("arst_ack",      72'(bus.usr_ack),  72'(0));
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;
        repeat (20) cycle(1'b1, 4'($urandom), 1'b1, 1'b1);
        repeat (10) cycle(1'b0, 4'h0, 1'b1, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
